// File: rtl/present_seq_pkg.sv
// present_seq_pkg: shared constants for the PRESENT LA sequencer.
// It holds the register addresses, the LA bit indices, the FSM states and the STATUS bit positions.
package present_seq_pkg;
    localparam logic [2:0] ADDR_KEY0   = 3'd0;
    localparam logic [2:0] ADDR_KEY1   = 3'd1;
    localparam logic [2:0] ADDR_KEY2   = 3'd2;
    localparam logic [2:0] ADDR_PT0    = 3'd3;
    localparam logic [2:0] ADDR_PT1    = 3'd4;
    localparam logic [2:0] ADDR_CT0    = 3'd5;
    localparam logic [2:0] ADDR_CT1    = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int LA_WR    = 35;
    localparam int LA_START = 36;
    localparam int LA_CLR   = 37;
    localparam int LA_DEC   = 38;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_TO   = 3;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, CAPTURE} seq_state_e;
endpackage

// File: rtl/la_sync_edge.sv
// la_sync_edge: two-flop synchronizer on W bits.
// A third stage on the EW bits starting at EL gives rising-edge detection.
module la_sync_edge #(
    parameter int W  = 39,
    parameter int EL = 35,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  d_i,
    output logic [W-1:0]  sync_o,
    output logic [EW-1:0] rise_o
);
    logic [W-1:0]  s1_q, s2_q;
    logic [EW-1:0] s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q[EL +: EW];
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q[EL +: EW] & ~s3_q;
endmodule

// File: rtl/present_la_sequencer.sv
// present_la_sequencer: drives the PRESENT-80 core from the LA command bus.
// Defining PRESENT_SEQ_TIMEOUT_EN enables a BUSY watchdog of TIMEOUT_CYCLES cycles.
module present_la_sequencer
    import present_seq_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef PRESENT_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [38:0] la_data_in,
    output logic [31:0] la_data_out,
    output logic [79:0] core_key,
    output logic [63:0] core_pt,
    output logic        core_dec,
    output logic        core_start,
    input  logic        core_done,
    input  logic [63:0] core_ct,
    output logic        irq
);
    logic [38:0]      la_s2;
    logic [2:0]       la_rise;
    logic [2:0]       unused_strb;
    logic             wr_e, start_e, clr_e;
    logic [2:0]       addr;
    logic [31:0]      wdata, status;
    seq_state_e       state_q, state_d;
    logic [79:0]      key_q, key_d;
    logic [63:0]      pt_q, pt_d, ct_q, ct_d;
    logic             dec_q, dec_d, done_q, done_d, ovr_q, ovr_d, irq_q, irq_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [31:0]      rd_q, rd_d;
`ifdef PRESENT_SEQ_TIMEOUT_EN
    logic             to_q, to_d;
`endif

    la_sync_edge #(.W(39), .EL(LA_WR), .EW(3)) u_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .d_i    (la_data_in),
        .sync_o (la_s2),
        .rise_o (la_rise)
    );

    assign wr_e        = la_rise[0];
    assign start_e     = la_rise[LA_START - LA_WR];
    assign clr_e       = la_rise[LA_CLR - LA_WR];
    assign addr        = la_s2[34:32];
    assign wdata       = la_s2[31:0];
    assign unused_strb = la_s2[LA_CLR:LA_WR];

    always_comb begin
        status = '0;
        status[ST_BUSY] = state_q != IDLE;
        status[ST_DONE] = done_q;
        status[ST_OVR] = ovr_q;
`ifdef PRESENT_SEQ_TIMEOUT_EN
        status[ST_TO] = to_q;
`endif
        status[15:8] = cnt_q;
        status[31:16] = 16'(lat_q);
    end

    always_comb begin
        case (addr)
            ADDR_KEY0: rd_d = key_q[31:0];
            ADDR_KEY1: rd_d = key_q[63:32];
            ADDR_KEY2: rd_d = {16'h0, key_q[79:64]};
            ADDR_PT0:  rd_d = pt_q[31:0];
            ADDR_PT1:  rd_d = pt_q[63:32];
            ADDR_CT0:  rd_d = ct_q[31:0];
            ADDR_CT1:  rd_d = ct_q[63:32];
            default:   rd_d = status;
        endcase
    end

    always_comb begin
        state_d = state_q;
        key_d = key_q;
        pt_d = pt_q;
        ct_d = ct_q;
        dec_d = dec_q;
        done_d = done_q;
        ovr_d = ovr_q;
        irq_d = irq_q;
        cnt_d = cnt_q;
        lat_d = lat_q;
`ifdef PRESENT_SEQ_TIMEOUT_EN
        to_d = to_q;
`endif
        // Clear is applied first so a completion in the same cycle still raises irq.
        if (clr_e) begin
            done_d = 1'b0;
            ovr_d = 1'b0;
            irq_d = 1'b0;
`ifdef PRESENT_SEQ_TIMEOUT_EN
            to_d = 1'b0;
`endif
        end
        if (wr_e && addr <= ADDR_PT1) begin
            if (state_q != IDLE) ovr_d = 1'b1;
            else begin
                case (addr)
                    ADDR_KEY0: key_d[31:0] = wdata;
                    ADDR_KEY1: key_d[63:32] = wdata;
                    ADDR_KEY2: key_d[79:64] = wdata[15:0];
                    ADDR_PT0:  pt_d[31:0] = wdata;
                    default:   pt_d[63:32] = wdata;
                endcase
            end
        end
        if (start_e && state_q != IDLE) ovr_d = 1'b1;
        case (state_q)
            IDLE: if (start_e) begin
                state_d = LAUNCH;
                dec_d = la_s2[LA_DEC];
                done_d = 1'b0;
            end
            LAUNCH: begin
                lat_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                lat_d = (&lat_q) ? lat_q : lat_q + 1'b1;
                if (core_done) begin
                    ct_d = core_ct;
                    state_d = CAPTURE;
                end
`ifdef PRESENT_SEQ_TIMEOUT_EN
                else if (lat_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_d = 1'b1;
                    irq_d = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            CAPTURE: begin
                done_d = 1'b1;
                irq_d = 1'b1;
                cnt_d = cnt_q + 8'd1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            key_q <= '0;
            pt_q <= '0;
            ct_q <= '0;
            dec_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q <= 1'b0;
            irq_q <= 1'b0;
            cnt_q <= '0;
            lat_q <= '0;
            rd_q <= '0;
`ifdef PRESENT_SEQ_TIMEOUT_EN
            to_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            pt_q <= pt_d;
            ct_q <= ct_d;
            dec_q <= dec_d;
            done_q <= done_d;
            ovr_q <= ovr_d;
            irq_q <= irq_d;
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            rd_q <= rd_d;
`ifdef PRESENT_SEQ_TIMEOUT_EN
            to_q <= to_d;
`endif
        end
    end

    assign la_data_out = rd_q;
    assign core_key = key_q;
    assign core_pt = pt_q;
    assign core_dec = dec_q;
    assign core_start = state_q == LAUNCH;
    assign irq = irq_q;
endmodule

// File: tb/tb_present_la_sequencer.sv
// tb_present_la_sequencer: scoreboard bench with a behavioural core model.
module tb_present_la_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [38:0] la = '0;
    logic [31:0] la_data_out;
    logic [79:0] core_key;
    logic [63:0] core_pt;
    logic        core_dec, core_start, core_done, irq;
    logic [63:0] core_ct;

    typedef struct packed {logic dec; logic [79:0] key; logic [63:0] pt;} lexp_t;
    typedef struct {string tag; logic [31:0] mask; logic [31:0] val;} rexp_t;

    lexp_t       lq[$];
    rexp_t       rq[$];
    lexp_t       le;
    int          n_chk = 0, n_err = 0, n_start = 0, core_lat = 0, cd = 0;
    logic [63:0] cur_ct;
    logic [79:0] m_key = '0;
    logic [63:0] m_pt = '0, m_ct = '0;
    logic [7:0]  m_cnt = '0;

    present_la_sequencer dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .la_data_in  (la),
        .la_data_out (la_data_out),
        .core_key    (core_key),
        .core_pt     (core_pt),
        .core_dec    (core_dec),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_ct     (core_ct),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_ct(input logic [79:0] k, input logic [63:0] p, input logic d);
        if (!d && k == '0 && p == '0) return 64'h5579C1387B228445;
        return {p[31:0], p[63:32]} ^ k[79:16] ^ {64{d}};
    endfunction

    // Stand-in core: checks each launch against the queued expectation, answers after core_lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd = 0;
            core_done <= 1'b0;
            core_ct <= '0;
        end else begin
            core_done <= 1'b0;
            core_ct <= 64'hDEADDEADDEADDEAD;
            if (core_start) begin
                n_start++;
                check("pending_launch", 80'(lq.size() != 0), 80'(1));
                if (lq.size() != 0) begin
                    le = lq.pop_front();
                    check("core_key", core_key, le.key);
                    check("core_pt", 80'(core_pt), 80'(le.pt));
                    check("core_dec", 80'(core_dec), 80'(le.dec));
                end
                cur_ct = model_ct(core_key, core_pt, core_dec);
                if (core_lat == 1) begin
                    core_done <= 1'b1;
                    core_ct <= cur_ct;
                end else cd = (core_lat > 1) ? core_lat - 1 : 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_done <= 1'b1;
                    core_ct <= cur_ct;
                end
            end
        end
    end

    task automatic pulse(input logic [3:0] strb, input logic [2:0] a, input logic [31:0] d);
        la = {strb, a, d};
        repeat (4) @(posedge clk);
        #1 la = {4'b0, a, d};
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_key[31:0] = d;
            3'd1: m_key[63:32] = d;
            3'd2: m_key[79:64] = d[15:0];
            3'd3: m_pt[31:0] = d;
            3'd4: m_pt[63:32] = d;
            default: ;
        endcase
        pulse(4'b0001, a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic [31:0] mask, input string tag);
        rexp_t e;
        rq.push_back('{tag, mask, exp});
        la = {4'b0, a, 32'h0};
        repeat (4) @(posedge clk);
        #1 e = rq.pop_front();
        check(e.tag, 80'(la_data_out & e.mask), 80'(e.val & e.mask));
    endtask

    task automatic launch(input logic d, input int lat);
        core_lat = lat;
        lq.push_back(lexp_t'({d, m_key, m_pt}));
        pulse({d, 3'b010}, 3'd0, 32'd0);
    endtask

    task automatic complete_op(input logic d, input int lat);
        repeat (lat + 4) @(posedge clk);
        #1 m_ct = model_ct(m_key, m_pt, d);
        m_cnt++;
        check("irq_set", 80'(irq), 80'(1));
    endtask

    initial begin
        #1_000_000 $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int s0;
        #3;
        check("rst_rd", 80'(la_data_out), 80'(0));
        check("rst_start", 80'(core_start), 80'(0));
        check("rst_irq", 80'(irq), 80'(0));
        check("rst_key", core_key, 80'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(3'd7, 32'h0, 32'hFFFFFFFF, "status_reset");

        for (int i = 0; i < 5; i++) wr(3'(i), 32'h0);
        launch(1'b0, 32);
        complete_op(1'b0, 32);
        rd(3'd6, 32'h5579C138, 32'hFFFFFFFF, "ct1_enc");
        rd(3'd5, 32'h7B228445, 32'hFFFFFFFF, "ct0_enc");
        rd(3'd7, 32'h00200102, 32'hFFFFFFFF, "status_enc");

        wr(3'd0, 32'h01234567);
        wr(3'd1, 32'h89ABCDEF);
        wr(3'd2, 32'hDEADBEEF);
        wr(3'd3, 32'h0BADF00D);
        wr(3'd4, 32'hCAFEBABE);
        wr(3'd5, 32'hFFFFFFFF);
        rd(3'd0, 32'h01234567, 32'hFFFFFFFF, "key0_rb");
        rd(3'd1, 32'h89ABCDEF, 32'hFFFFFFFF, "key1_rb");
        rd(3'd2, 32'h0000BEEF, 32'hFFFFFFFF, "key2_rb");
        rd(3'd3, 32'h0BADF00D, 32'hFFFFFFFF, "pt0_rb");
        rd(3'd4, 32'hCAFEBABE, 32'hFFFFFFFF, "pt1_rb");
        rd(3'd5, m_ct[31:0], 32'hFFFFFFFF, "ct0_ro");
        rd(3'd7, 32'h2, 32'hF, "status_ro_noflag");

        launch(1'b1, 10);
        complete_op(1'b1, 10);
        rd(3'd5, m_ct[31:0], 32'hFFFFFFFF, "ct0_dec");
        rd(3'd6, m_ct[63:32], 32'hFFFFFFFF, "ct1_dec");
        rd(3'd7, 32'h000A0202, 32'hFFFFFFFF, "status_dec");

        // Write and start in the same cycle: the launch must carry the new PT0.
        m_pt[31:0] = 32'h5EED5EED;
        core_lat = 8;
        lq.push_back(lexp_t'({1'b1, m_key, m_pt}));
        pulse(4'b1011, 3'd3, 32'h5EED5EED);
        complete_op(1'b1, 8);
        rd(3'd3, 32'h5EED5EED, 32'hFFFFFFFF, "pt0_same_cycle");
        rd(3'd5, m_ct[31:0], 32'hFFFFFFFF, "ct0_same_cycle");

        s0 = n_start;
        launch(1'b0, 40);
        rd(3'd7, 32'h1, 32'hF, "status_busy");
        check("irq_kept_on_start", 80'(irq), 80'(1));
        pulse(4'b0010, 3'd0, 32'h0);
        pulse(4'b0001, 3'd0, 32'h12345678);
        complete_op(1'b0, 40);
        check("single_start", 80'(n_start - s0), 80'(1));
        rd(3'd7, 32'h00280406, 32'hFFFFFFFF, "status_overrun");
        rd(3'd0, m_key[31:0], 32'hFFFFFFFF, "key0_busy_write");

        pulse(4'b0100, 3'd0, 32'h0);
        check("irq_clear", 80'(irq), 80'(0));
        rd(3'd7, 32'h0, 32'hF, "status_clear");
        rd(3'd6, m_ct[63:32], 32'hFFFFFFFF, "ct1_retained");

        while (m_cnt != 8'd0) begin
            launch(1'b0, 1);
            complete_op(1'b0, 1);
        end
        rd(3'd7, 32'h00010002, 32'hFFFFFFFF, "status_wrap");

        launch(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd", 80'(la_data_out), 80'(0));
        check("mid_rst_key", core_key, 80'(0));
        check("mid_rst_pt", 80'(core_pt), 80'(0));
        check("mid_rst_start", 80'(core_start), 80'(0));
        check("mid_rst_dec", 80'(core_dec), 80'(0));
        check("mid_rst_irq", 80'(irq), 80'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_key = '0;
        m_pt = '0;
        m_ct = '0;
        m_cnt = '0;
        rd(3'd7, 32'h0, 32'hFFFFFFFF, "status_after_rst");
        rd(3'd6, 32'h0, 32'hFFFFFFFF, "ct1_after_rst");
        launch(1'b0, 5);
        complete_op(1'b0, 5);
        rd(3'd7, 32'h00050102, 32'hFFFFFFFF, "status_post_rst");
        rd(3'd6, 32'h5579C138, 32'hFFFFFFFF, "ct1_post_rst");

`ifdef PRESENT_SEQ_TIMEOUT_EN
        pulse(4'b0100, 3'd0, 32'h0);
        launch(1'b0, 0);
        repeat (80) @(posedge clk);
        #1 check("irq_timeout", 80'(irq), 80'(1));
        rd(3'd7, {16'h0, m_cnt, 8'h08}, 32'h0000FFFF, "status_timeout");
        rd(3'd5, m_ct[31:0], 32'hFFFFFFFF, "ct0_timeout");
`endif

        check("launch_queue_empty", 80'(lq.size()), 80'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
